// File: rtl/matrix_vector_row_sequencer_pkg.sv
// Shared definitions for the matrix-vector row sequencer: FSM encoding and in-flight limits.
package row_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_ADDR,
    S_BEAT,
    S_DRAIN
  } state_t;

  localparam logic [1:0] MAX_IN_FLIGHT  = 2'd2;
  localparam int         TAG_FIFO_DEPTH = 2;

endpackage

// File: rtl/matrix_vector_row_sequencer_row_tag_fifo.sv
// Depth-2 tag FIFO: holds row indices of rows started but whose result has not yet returned.
module row_tag_fifo import row_seq_pkg::*; #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);

  logic [TAG_FIFO_DEPTH-1:0][W-1:0] mem;
  logic wr_ptr, rd_ptr;
  logic full, do_push, do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(TAG_FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/matrix_vector_row_sequencer.sv
// Sequences a matrix-by-vector pass row by row, overlapping feed of row N+1 with drain of row N.
// Optional ROW_SEQ_STATS_EN adds stall_cycles/active_cycles counters.
module matrix_vector_row_sequencer import row_seq_pkg::*; #(
  parameter int element_width                = 32,
  parameter int multiples_memory_value_width = 3,
  parameter int row_index_width              = 6,
  parameter int chunk_addr_width             = 9
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [row_index_width:0]                no_of_rows,
  output logic [row_index_width-1:0]              multiples_rd_addr,
  input  logic [multiples_memory_value_width-1:0] multiples_rd_data,
  output logic [chunk_addr_width-1:0]             chunk_rd_addr,
  output logic                                    start_row_by_vector,
  output logic [multiples_memory_value_width-1:0] no_of_multiples,
  output logic                                    you_can_read,
  input  logic                                    I_am_ready,
  input  logic                                    give_me_only,
  input  logic                                    decoder_read_now,
  input  logic [element_width-1:0]                row_result,
  output logic                                    result_wr_en,
  output logic [row_index_width-1:0]              result_wr_addr,
  output logic [element_width-1:0]                result_wr_data,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    tag_error
`ifdef ROW_SEQ_STATS_EN
  ,
  output logic [31:0]                             stall_cycles,
  output logic [31:0]                             active_cycles
`endif
);

  localparam int RW = row_index_width;
  localparam int MW = multiples_memory_value_width;
  localparam int CW = chunk_addr_width;
  localparam logic [RW:0]   ROW_ONE   = {{RW{1'b0}}, 1'b1};
  localparam logic [MW-1:0] MULT_ONE  = {{(MW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CHUNK_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state;
  logic [RW:0]   rows_total;
  logic [RW-1:0] row_ptr;
  logic [CW-1:0] chunk_ptr;
  logic [MW-1:0] beats;
  logic [RW:0]   next_row;
  logic [RW-1:0] fifo_head;
  logic [1:0]    in_flight;
  logic          fifo_empty, issue_go, beat, last_beat, more_rows;

  // Both memory addresses are the pointer registers themselves, so they are registered outputs.
  assign multiples_rd_addr = row_ptr;
  assign chunk_rd_addr     = chunk_ptr;

  assign issue_go  = (state == S_ISSUE) && I_am_ready && (in_flight < MAX_IN_FLIGHT);
  assign beat      = (state == S_BEAT) && you_can_read && I_am_ready;
  assign last_beat = (beats + MULT_ONE) >= no_of_multiples;
  assign next_row  = {1'b0, row_ptr} + ROW_ONE;
  assign more_rows = next_row < rows_total;

  row_tag_fifo #(.W(RW)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue_go),
    .pop   (decoder_read_now),
    .din   (row_ptr),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .count (in_flight)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      rows_total          <= '0;
      row_ptr             <= '0;
      chunk_ptr           <= '0;
      beats               <= '0;
      no_of_multiples     <= '0;
      start_row_by_vector <= 1'b0;
      you_can_read        <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      start_row_by_vector <= 1'b0;
      done                <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (no_of_rows == '0) done <= 1'b1;
          else begin
            rows_total <= no_of_rows;
            row_ptr    <= '0;
            chunk_ptr  <= '0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          // A zero count still needs one beat so the datapath sees a well-formed row.
          no_of_multiples <= (multiples_rd_data == '0) ? MULT_ONE : multiples_rd_data;
          beats           <= '0;
          state           <= S_ISSUE;
        end
        S_ISSUE: if (issue_go) begin
          start_row_by_vector <= 1'b1;
          state               <= S_ADDR;
        end
        S_ADDR: begin
          you_can_read <= 1'b1;
          state        <= S_BEAT;
        end
        S_BEAT: if (beat) begin
          you_can_read <= 1'b0;
          chunk_ptr    <= chunk_ptr + CHUNK_ONE;
          beats        <= beats + MULT_ONE;
          if (!last_beat) state <= S_ADDR;
          else begin
            row_ptr <= next_row[RW-1:0];
            state   <= more_rows ? S_FETCH : S_DRAIN;
          end
        end
        S_DRAIN: if (fifo_empty) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result write-back runs independently of the feed FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_wr_en   <= 1'b0;
      result_wr_addr <= '0;
      result_wr_data <= '0;
      tag_error      <= 1'b0;
    end else begin
      result_wr_en <= decoder_read_now & ~fifo_empty;
      if (decoder_read_now & ~fifo_empty) begin
        result_wr_addr <= fifo_head;
        result_wr_data <= row_result;
      end
      if (decoder_read_now & fifo_empty) tag_error <= 1'b1;
      if ((state == S_BEAT) && give_me_only && !(beat && last_beat)) tag_error <= 1'b1;
    end
  end

`ifdef ROW_SEQ_STATS_EN
  logic stall;
  assign stall = ((state == S_ISSUE) && !issue_go) ||
                 ((state == S_BEAT) && you_can_read && !I_am_ready);

  always_ff @(posedge clk) begin
    if (reset || ((state == S_IDLE) && start)) begin
      stall_cycles  <= '0;
      active_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (busy && (active_cycles != '1)) active_cycles <= active_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_matrix_vector_row_sequencer.sv
// Randomized bench for matrix_vector_row_sequencer with a queue-based reference model.
module tb_matrix_vector_row_sequencer;
  localparam int EW = 32, MW = 3, RW = 6, CW = 9;

  logic          clk = 1'b0;
  logic          reset, start, give_me_only;
  logic [RW:0]   no_of_rows;
  logic [RW-1:0] multiples_rd_addr;
  logic [MW-1:0] multiples_rd_data = '0;
  logic [CW-1:0] chunk_rd_addr;
  logic          start_row_by_vector, you_can_read;
  logic [MW-1:0] no_of_multiples;
  logic          I_am_ready = 1'b0, decoder_read_now = 1'b0;
  logic [EW-1:0] row_result = '0;
  logic          result_wr_en;
  logic [RW-1:0] result_wr_addr;
  logic [EW-1:0] result_wr_data;
  logic          busy, done, tag_error;
`ifdef ROW_SEQ_STATS_EN
  logic [31:0]   stall_cycles, active_cycles;
`endif

  always #5 clk = ~clk;

  matrix_vector_row_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .no_of_rows(no_of_rows),
    .multiples_rd_addr(multiples_rd_addr), .multiples_rd_data(multiples_rd_data),
    .chunk_rd_addr(chunk_rd_addr), .start_row_by_vector(start_row_by_vector),
    .no_of_multiples(no_of_multiples), .you_can_read(you_can_read),
    .I_am_ready(I_am_ready), .give_me_only(give_me_only),
    .decoder_read_now(decoder_read_now), .row_result(row_result),
    .result_wr_en(result_wr_en), .result_wr_addr(result_wr_addr),
    .result_wr_data(result_wr_data), .busy(busy), .done(done), .tag_error(tag_error)
`ifdef ROW_SEQ_STATS_EN
    , .stall_cycles(stall_cycles), .active_cycles(active_cycles)
`endif
  );

  // Multiples memory with one cycle of read latency.
  logic [MW-1:0] mmem [64];
  always @(posedge clk) multiples_rd_data <= mmem[multiples_rd_addr];

  typedef struct { int row; logic [EW-1:0] data; } res_t;
  int   exp_mult[$];
  int   exp_addr[$];
  res_t exp_res[$];

  int n_vec = 0, n_err = 0;
  int starts_seen = 0, beats_seen = 0, dones = 0, reads_issued = 0;
  int start_base = 0, read_base = 0;
  bit mon_en = 0, rdy_rand = 0, rd_en = 0, force_rd = 0, err_arm = 0, exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outstanding();
    return (starts_seen - start_base) - (reads_issued - read_base);
  endfunction

  // Datapath stand-in: random back-pressure and result return for started rows.
  always @(posedge clk) begin
    #1;
    err_arm = 1'b0;
    decoder_read_now = 1'b0;
    I_am_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (force_rd || (rd_en && outstanding() > 0 && $urandom_range(0, 2) == 0)) begin
      decoder_read_now = 1'b1;
      row_result = $urandom;
      if (outstanding() > 0) begin
        res_t r;
        r.row  = reads_issued - read_base;
        r.data = row_result;
        exp_res.push_back(r);
        reads_issued++;
      end else err_arm = 1'b1;
    end
  end

  // Compare process: every observable event is matched against the model queues.
  always @(negedge clk) begin
    if (!mon_en) exp_err = 1'b0;
    else begin
      if (start_row_by_vector) begin
        starts_seen++;
        chk("start_expected", exp_mult.size() > 0, 1);
        if (exp_mult.size() > 0) chk("no_of_multiples", no_of_multiples, exp_mult.pop_front());
        chk("in_flight_le2", outstanding() <= 2, 1);
      end
      if (you_can_read && I_am_ready) begin
        beats_seen++;
        chk("beat_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("chunk_rd_addr", chunk_rd_addr, exp_addr.pop_front());
      end
      if (result_wr_en) begin
        chk("wr_expected", exp_res.size() > 0, 1);
        if (exp_res.size() > 0) begin
          res_t e;
          e = exp_res.pop_front();
          chk("result_wr_addr", result_wr_addr, e.row);
          chk("result_wr_data", result_wr_data, e.data);
        end
      end
      chk("tag_error", tag_error, exp_err);
      if (err_arm) exp_err = 1'b1;
      if (done) dones++;
    end
  end

  task automatic start_pass(input int n, input bit rr);
    int addr = 0;
    rdy_rand = rr;
    for (int r = 0; r < n; r++) begin
      int c = (mmem[r] == 0) ? 1 : int'(mmem[r]);
      exp_mult.push_back(c);
      for (int b = 0; b < c; b++) begin
        exp_addr.push_back(addr % 512);
        addr++;
      end
    end
    start_base = starts_seen;
    read_base  = reads_issued;
    no_of_rows = 7'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_pass(input int d0);
    int cyc = 0;
    while (dones == d0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("pass_done_in_time", dones != d0, 1);
    repeat (2) @(negedge clk);
    chk("pass_done_count", dones - d0, 1);
    chk("pass_starts_left", exp_mult.size(), 0);
    chk("pass_beats_left", exp_addr.size(), 0);
    chk("pass_results_left", exp_res.size(), 0);
    chk("pass_idle", busy, 0);
  endtask

  task automatic run_pass(input int n, input bit rr);
    int d0 = dones;
    start_pass(n, rr);
    if (n > 1) begin
      repeat (3) @(negedge clk);
      no_of_rows = 7'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    finish_pass(d0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_start_rbv"}, start_row_by_vector, 0);
    chk({tag, "_you_can_read"}, you_can_read, 0);
    chk({tag, "_wr_en"}, result_wr_en, 0);
    chk({tag, "_tag_error"}, tag_error, 0);
    chk({tag, "_mult_addr"}, multiples_rd_addr, 0);
    chk({tag, "_chunk_addr"}, chunk_rd_addr, 0);
    chk({tag, "_no_of_mult"}, no_of_multiples, 0);
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    rd_en  = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    exp_mult.delete();
    exp_addr.delete();
    exp_res.delete();
    start_base = starts_seen;
    read_base  = reads_issued;
  endtask

  initial begin
    int s0, b0, cyc;
    reset = 1'b1; start = 1'b0; no_of_rows = '0; give_me_only = 1'b0;
    for (int i = 0; i < 64; i++) mmem[i] = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    reset = 1'b0; mon_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);

    // Directed pass: multiples {2,1,3}, always ready -> 3 starts, 6 beats at 0..5.
    mmem[0] = 3'd2; mmem[1] = 3'd1; mmem[2] = 3'd3;
    s0 = starts_seen; b0 = beats_seen;
    run_pass(3, 1'b0);
    chk("t1_starts", starts_seen - s0, 3);
    chk("t1_beats", beats_seen - b0, 6);

    // Zero rows: done the next cycle, nothing started.
    s0 = starts_seen;
    no_of_rows = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_rows_done", done, 1);
    chk("zero_rows_busy", busy, 0);
    @(negedge clk);
    chk("zero_rows_done_pulse", done, 0);
    chk("zero_rows_starts", starts_seen - s0, 0);

    // Zero count clamps to one beat.
    mmem[0] = 3'd0;
    b0 = beats_seen;
    run_pass(1, 1'b1);
    chk("clamp_beats", beats_seen - b0, 1);
    chk("clamp_no_of_mult", no_of_multiples, 1);

    // Results withheld: third ISSUE stalls at two rows in flight.
    mmem[0] = 3'd1; mmem[1] = 3'd1; mmem[2] = 3'd1;
    rd_en = 1'b0;
    s0 = dones;
    start_pass(3, 1'b0);
    cyc = 0;
    while (starts_seen - start_base < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (10) @(negedge clk);
    chk("stall_starts", starts_seen - start_base, 2);
    chk("stall_busy", busy, 1);
    force_rd = 1'b1;
    @(negedge clk);
    force_rd = 1'b0;
    @(negedge clk);
    chk("stall_hold", start_row_by_vector, 0);
    @(negedge clk);
    chk("stall_release", start_row_by_vector, 1);
    rd_en = 1'b1;
    finish_pass(s0);

    // Random passes, including the full 64-row case.
    for (int k = 0; k < 6; k++) begin
      int n = $urandom_range(1, 10);
      for (int i = 0; i < 64; i++) mmem[i] = 3'($urandom_range(0, 7));
      run_pass(n, 1'b1);
    end
    for (int i = 0; i < 64; i++) mmem[i] = 3'($urandom_range(0, 7));
    run_pass(64, 1'b1);

    // Result with nothing in flight: sticky tag_error, no write.
    force_rd = 1'b1;
    @(negedge clk);
    force_rd = 1'b0;
    repeat (5) @(negedge clk);
    chk("tag_error_sticky", tag_error, 1);
    chk("no_wr_on_empty", result_wr_en, 0);
    apply_reset();
    chk("tag_error_cleared", tag_error, 0);
    mon_en = 1'b1; rd_en = 1'b1;

    // Reset in the middle of row 1's beats, then a clean 2-row pass.
    mmem[0] = 3'd3; mmem[1] = 3'd3; mmem[2] = 3'd3;
    start_pass(3, 1'b1);
    cyc = 0;
    while (!(starts_seen - start_base == 2 && you_can_read) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midbeat_reached", starts_seen - start_base == 2 && you_can_read, 1);
    apply_reset();
    @(negedge clk);
    chk("post_reset_idle", busy, 0);
    chk("post_reset_no_done", done, 0);
    mon_en = 1'b1; rd_en = 1'b1;
    mmem[0] = 3'd2; mmem[1] = 3'd3;
    b0 = beats_seen;
    run_pass(2, 1'b1);
    chk("after_reset_beats", beats_seen - b0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
